// File: rtl/prog_loader_if.sv
// Byte-in / word-out bus between the UART receiver, the loader and the BIP
// program memory. The loader uses the slave view; the environment uses master.
interface prog_loader_if #(
  parameter int DBIT    = 8,
  parameter int NBITS_D = 16,
  parameter int NBITS_O = 11
);
  logic               i_start;
  logic               i_rx_done;
  logic [DBIT-1:0]    i_rx_data;
  logic               o_wr_en;
  logic [NBITS_O-1:0] o_wr_addr;
  logic [NBITS_D-1:0] o_wr_data;
  logic               o_bip_reset;
  logic               o_done;
  logic               o_err;

  modport slave (
    input  i_start, i_rx_done, i_rx_data,
    output o_wr_en, o_wr_addr, o_wr_data, o_bip_reset, o_done, o_err
  );

  modport master (
    output i_start, i_rx_done, i_rx_data,
    input  o_wr_en, o_wr_addr, o_wr_data, o_bip_reset, o_done, o_err
  );
endinterface

// File: rtl/prog_loader.sv
// UART program loader: pairs received bytes (low first) into instruction
// words, writes them to consecutive program memory addresses and keeps the
// BIP in reset until N_WORDS words are stored.
module prog_loader #(
  parameter int DBIT    = 8,
  parameter int NBITS_D = 16,
  parameter int NBITS_O = 11,
  parameter int N_WORDS = 10,
  parameter int TIMEOUT = 100000
) (
  input logic          i_clk,
  input logic          i_reset,
  prog_loader_if.slave bus
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]      TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [NBITS_O-1:0] ADDR_LAST  = NBITS_O'(N_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_LO, S_WAIT_HI, S_WRITE, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [DBIT-1:0]    lo_q, lo_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               wr_en_q, wr_en_d;
  logic [NBITS_O-1:0] wr_addr_q, wr_addr_d;
  logic [NBITS_D-1:0] wr_data_q, wr_data_d;
  logic               bip_reset_q, bip_reset_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; a start pulse restarts the load from any state
  always_comb begin
    state_d = state_q;
    if (bus.i_start) begin
      state_d = S_WAIT_LO;
    end else begin
      unique case (state_q)
        S_IDLE:    state_d = S_IDLE;
        S_WAIT_LO: if (bus.i_rx_done) state_d = S_WAIT_HI;
        S_WAIT_HI: begin
          // a byte arriving on the timeout cycle still completes the word
          if (bus.i_rx_done)              state_d = S_WRITE;
          else if (timer_q == TIMER_LAST) state_d = S_WAIT_LO;
        end
        S_WRITE:   state_d = (wr_addr_q == ADDR_LAST) ? S_DONE : S_WAIT_LO;
        S_DONE:    state_d = S_DONE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Datapath and registered-output next values
  always_comb begin
    lo_d      = lo_q;
    timer_d   = timer_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = err_q;
    if (bus.i_start) begin
      wr_addr_d = '0;
      err_d     = 1'b0;
    end else begin
      unique case (state_q)
        S_WAIT_LO: begin
          if (bus.i_rx_done) begin
            lo_d    = bus.i_rx_data;
            timer_d = '0;
          end
        end
        S_WAIT_HI: begin
          if (bus.i_rx_done) begin
            wr_data_d = {bus.i_rx_data, lo_q};
            wr_en_d   = 1'b1;
          end else if (timer_q == TIMER_LAST) begin
            err_d   = 1'b1;
            lo_d    = '0;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        S_WRITE: begin
          // address saturates at the last word instead of wrapping
          if (wr_addr_q != ADDR_LAST) wr_addr_d = wr_addr_q + NBITS_O'(1);
          if (bus.i_rx_done)          err_d     = 1'b1;
        end
        default: ;
      endcase
    end
    // derived from the next state so both flags switch on the same edge
    done_d      = (state_d == S_DONE);
    bip_reset_d = (state_d != S_DONE);
  end

  // Datapath and output registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      lo_q        <= '0;
      timer_q     <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      bip_reset_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      lo_q        <= lo_d;
      timer_q     <= timer_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      bip_reset_q <= bip_reset_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.o_wr_en     = wr_en_q;
  assign bus.o_wr_addr   = wr_addr_q;
  assign bus.o_wr_data   = wr_data_q;
  assign bus.o_bip_reset = bip_reset_q;
  assign bus.o_done      = done_q;
  assign bus.o_err       = err_q;

endmodule

// File: doc/prog_loader.md
# prog_loader

UART program loader for the BIP core: consumes received bytes from `uart_rx` and assembles them into 16-bit instruction words. Writes each word sequentially into the BIP program memory and holds the BIP in reset until the whole program is loaded. Sits upstream of `bip`, on the same clock (`clk_out1`) as `uart_tx` and `mod_m_counter`.

## Interface

Parameters:
- `DBIT`, 8 — UART data bits per byte.
- `NBITS_D`, 16 — instruction word width; must equal 2*`DBIT`.
- `NBITS_O`, 11 — program memory address width.
- `N_WORDS`, 10 — words per program; range 1..2**`NBITS_O`.
- `TIMEOUT`, 100000 — maximum clocks between the low and high byte of one word (10 ms at 10 MHz).

Ports:
- `i_clk` in 1 — the single clock, rising edge.
- `i_reset` in 1 — asynchronous, active-high reset.
- `i_start` in 1 — one-cycle pulse that arms or restarts a load.
- `i_rx_done` in 1 — one-cycle pulse from `uart_rx`; `i_rx_data` valid in the same cycle.
- `i_rx_data` in `DBIT` — received byte.
- `o_wr_en` out 1 — program memory write strobe, one cycle per word.
- `o_wr_addr` out `NBITS_O` — write address.
- `o_wr_data` out `NBITS_D` — write data, {high byte, low byte}.
- `o_bip_reset` out 1 — reset to `bip`; high while not loaded.
- `o_done` out 1 — program loaded; level signal.
- `o_err` out 1 — sticky framing error (timeout or dropped byte).

## Operation

- All outputs are registered.
- Reset values, applied immediately on `i_reset` without a clock edge:
  - state IDLE
  - `o_wr_en`=0, `o_wr_addr`=0, `o_wr_data`=0
  - `o_bip_reset`=1, `o_done`=0, `o_err`=0
  - internal low-byte register=0, timer=0
- Bytes arrive low byte first, then high byte: word = {`i_rx_data`(high), low}.
- States:
  - IDLE: waits for `i_start`. On `i_start`: clear `o_err`, set address=0, go to WAIT_LO. `i_rx_done` is ignored.
  - WAIT_LO: on `i_rx_done`, latch the low byte, clear the timer, go to WAIT_HI.
  - WAIT_HI: timer increments every cycle.
    - On `i_rx_done`: load `o_wr_data`={byte, low}, go to WRITE.
    - Otherwise, when timer = `TIMEOUT`-1: set `o_err`=1, discard the low byte, go to WAIT_LO. No write occurs.
  - WRITE: `o_wr_en`=1 for exactly this one cycle at the current `o_wr_addr`.
    - If `o_wr_addr` = `N_WORDS`-1: go to DONE.
    - Otherwise: increment the address and go to WAIT_LO.
    - An `i_rx_done` in WRITE is dropped and sets `o_err`.
  - DONE: `o_done`=1 and `o_bip_reset`=0. `i_rx_done` is ignored. On `i_start`: behave as from IDLE (clear `o_err`, address=0, go to WAIT_LO).
- `o_bip_reset` is 1 in every state except DONE. It falls on the same edge `o_done` rises and rises on the same edge `o_done` falls.
- `i_start` in any state restarts the load, with priority over `i_rx_done` in the same cycle:
  - address=0, `o_err`=0, `o_done`=0, `o_bip_reset`=1
  - go to WAIT_LO
- Simultaneous `i_rx_done` and timeout in WAIT_HI: the byte wins. The word is written and `o_err` is unchanged.
- Address never wraps; the load stops at `N_WORDS`-1.
- Timer width is `$clog2(TIMEOUT)`; it never exceeds `TIMEOUT`-1.

## Timing

- Cycle timing from the edge E that samples the high byte's `i_rx_done`:
  - `o_wr_en`, `o_wr_addr` and `o_wr_data` are valid from E until E+1.
  - `o_wr_en` is low again after E+1.
- Last word: `o_done`=1 and `o_bip_reset`=0 from E+1.
- `o_wr_addr` increments at E+1 and holds otherwise.
- Timeout: `o_err` rises `TIMEOUT` edges after the edge that sampled the low byte.
- `i_start` takes effect at the edge that samples it; the first byte is accepted from the following cycle.
- Throughput: at 115200 baud and 10 MHz, about 868 clocks per byte, so WRITE never collides with a byte in normal operation.

## Test plan

- Reset: assert `i_reset` asynchronously mid-cycle, with no clock. All outputs go to their reset values immediately: `o_bip_reset`=1, others 0.
- Full load, `N_WORDS`=10: pulse `i_start`, then send the byte pairs (`k`, 0xA5) for k=0..9. Required: ten single-cycle writes at addr k with data 0xA500+k. `o_done`=1 and `o_bip_reset`=0 one edge after the last high byte. Further bytes produce no writes.
- Timeout, `TIMEOUT`=50: send 0x34, wait 60 clocks. Required: `o_err`=1 and no write. Then send 0x78, 0x56: write at addr 0 with data 0x5678, and `o_err` stays 1.
- Boundary, `TIMEOUT`=50: send the high byte exactly on the timeout cycle. Required: word written and `o_err`=0.
- Restart: after 3 words, pulse `i_start`. Required: `o_wr_addr`=0 and `o_err`=0; the next pair writes addr 0. Also pulse `i_start` in DONE: `o_bip_reset` returns to 1 and `o_done` to 0 at the same edge.
- Reset mid-load: assert `i_reset` in WAIT_HI. Required: state IDLE and address 0. Bytes received before `i_start` produce no writes.
